// File: rtl/fcfs_arbiter_param_if.sv
// Request/grant bundle between the bus masters and the FCFS arbiter.
// The arbiter side uses the slave modport, the requesting side the master modport.
interface fcfs_arbiter_param_if #(
  parameter int N_REQ = 4
) ();
  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = $clog2(N_REQ + 1);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IDW-1:0]   gnt_id;
  logic [CNTW-1:0]  queue_count;
  logic             timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  queue_count,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output queue_count,
    output timeout
  );
endinterface

// File: rtl/fcfs_arbiter_param.sv
// First-come-first-served arbiter for N_REQ requesters.
// Rising requests are queued in arrival order (ascending index on ties) and
// granted from the queue head. Optional hold timeout preempts the owner and
// sends it to the back of the queue.
//
//  state   | meaning
//  S_IDLE  | no grant; pop queue head each cycle, grant it if still requesting
//  S_GRANT | one requester owns the resource; watch for release or timeout
module fcfs_arbiter_param #(
  parameter int  N_REQ    = 4,
  parameter int  MAX_HOLD = 0,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 resetn,
  fcfs_arbiter_param_if.slave  bus
);

  localparam int CNTW = $clog2(N_REQ + 1);
  // Hold counter needs to reach MAX_HOLD; at least one bit even when disabled.
  localparam int HW   = $clog2(MAX_HOLD + 2);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [IDW-1:0] LAST_SLOT = IDW'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_gnt_valid;
  logic [IDW-1:0]   r_gnt_id;
  logic             r_timeout;
  logic [HW-1:0]    r_hold;

  logic [IDW-1:0]   r_q [N_REQ];
  logic [IDW-1:0]   r_head;
  logic [IDW-1:0]   r_tail;
  logic [CNTW-1:0]  r_count;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_req_q;

  logic [N_REQ-1:0] w_arrive;
  logic [IDW-1:0]   w_head_id;
  logic             w_q_nonempty;
  logic             w_owner_req;
  logic             w_release;
  logic             w_expire;
  logic             w_pop;
  logic             w_head_live;
  logic             w_requeue;
  logic [N_REQ-1:0] w_pop_mask;
  logic [N_REQ-1:0] w_requeue_mask;
  logic [IDW-1:0]   w_q_next [N_REQ];
  logic [IDW-1:0]   w_tail_next;
  logic [CNTW-1:0]  w_push_cnt;

  function automatic logic [IDW-1:0] slot_inc(input logic [IDW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // A new arrival is a fresh rising edge from a requester that is neither
  // queued nor currently owning the resource.
  assign w_arrive     = bus.req & ~r_req_q & ~r_pending & ~r_gnt;
  assign w_head_id    = r_q[r_head];
  assign w_q_nonempty = (r_count != '0);
  assign w_owner_req  = |(bus.req & r_gnt);
  assign w_release    = (r_state == S_GRANT) && !w_owner_req;
  assign w_expire     = (MAX_HOLD > 0) && (r_state == S_GRANT) && w_owner_req &&
                        (r_hold == HOLD_MAX);
  assign w_pop        = w_q_nonempty && ((r_state == S_IDLE) || w_release || w_expire);
  assign w_head_live  = bus.req[w_head_id];
  // With an empty queue a timed-out owner is simply re-granted, not queued.
  assign w_requeue    = w_expire && w_q_nonempty;
  assign w_pop_mask     = w_pop ? (N_REQ'(1) << w_head_id) : '0;
  assign w_requeue_mask = w_requeue ? r_gnt : '0;

  // Tail writes: same-edge arrivals in ascending index, then the preempted owner.
  always_comb begin
    w_q_next    = r_q;
    w_tail_next = r_tail;
    w_push_cnt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arrive[i]) begin
        w_q_next[w_tail_next] = IDW'(i);
        w_tail_next           = slot_inc(w_tail_next);
        w_push_cnt            = w_push_cnt + 1'b1;
      end
    end
    if (w_requeue) begin
      w_q_next[w_tail_next] = r_gnt_id;
      w_tail_next           = slot_inc(w_tail_next);
      w_push_cnt            = w_push_cnt + 1'b1;
    end
  end

  // Arrival-order queue, pending flags and request history.
  // History resets high so a request held through reset needs a fresh rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q       <= '{default: '0};
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_req_q   <= '1;
    end else begin
      r_q       <= w_q_next;
      r_tail    <= w_tail_next;
      if (w_pop) begin
        r_head <= slot_inc(r_head);
      end
      r_count   <= r_count + w_push_cnt - CNTW'(w_pop);
      r_pending <= (r_pending & ~w_pop_mask) | w_arrive | w_requeue_mask;
      r_req_q   <= bus.req;
    end
  end

  // Grant state machine; all grant outputs are registered here together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_hold      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop && w_head_live) begin
            r_state     <= S_GRANT;
            r_gnt       <= w_pop_mask;
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_head_id;
            r_hold      <= HW'(1);
          end
        end
        S_GRANT: begin
          if (w_release || w_requeue) begin
            // Owner leaves: hand over to a live head at the same edge, else go idle.
            r_timeout <= w_requeue;
            if (w_pop && w_head_live) begin
              r_gnt    <= w_pop_mask;
              r_gnt_id <= w_head_id;
              r_hold   <= HW'(1);
            end else begin
              r_state     <= S_IDLE;
              r_gnt       <= '0;
              r_gnt_valid <= 1'b0;
              r_gnt_id    <= '0;
              r_hold      <= '0;
            end
          end else if (w_expire) begin
            // Nobody waiting: owner keeps the grant with a fresh hold window.
            r_timeout <= 1'b1;
            r_hold    <= HW'(1);
          end else if ((MAX_HOLD > 0) && (r_hold != HOLD_MAX)) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.gnt_valid   = r_gnt_valid;
  assign bus.gnt_id      = r_gnt_id;
  assign bus.queue_count = r_count;
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_fcfs_arbiter_param.sv
// Bench for fcfs_arbiter_param: dut_a without timeout, dut_b with MAX_HOLD=3.
module tb_fcfs_arbiter_param;
  localparam int N = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fcfs_arbiter_param_if #(.N_REQ(N)) ifa ();
  fcfs_arbiter_param_if #(.N_REQ(N)) ifb ();

  fcfs_arbiter_param #(.N_REQ(N), .MAX_HOLD(0)) dut_a (.clk(clk), .resetn(resetn), .bus(ifa));
  fcfs_arbiter_param #(.N_REQ(N), .MAX_HOLD(3)) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of waiting indices, owner index (-1 = none).
  int         mq    [2][$];
  bit [N-1:0] mpend [2];
  logic [N-1:0] mprev [2];
  int         mown  [2];
  int         mhold [2];
  bit         mtmo  [2];
  int         mmax  [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mpend[m] = '0;
      mprev[m] = '1;
      mown[m]  = -1;
      mhold[m] = 0;
      mtmo[m]  = 1'b0;
    end
    mmax[0] = 0;
    mmax[1] = 3;
  endtask

  task automatic model_step(input int m, input logic [N-1:0] r);
    int  arr[$];
    bit  had, rel, expd;
    int  popped;
    popped = -1;
    had  = (mq[m].size() > 0);
    for (int i = 0; i < N; i++)
      if (r[i] && !mprev[m][i] && !mpend[m][i] && mown[m] != i) arr.push_back(i);
    rel  = (mown[m] >= 0) && !r[mown[m]];
    expd = (mown[m] >= 0) && r[mown[m]] && (mmax[m] > 0) && (mhold[m] == mmax[m]);
    if (had && (mown[m] < 0 || rel || expd)) begin
      popped = mq[m].pop_front();
      mpend[m][popped] = 1'b0;
    end
    foreach (arr[k]) begin
      mq[m].push_back(arr[k]);
      mpend[m][arr[k]] = 1'b1;
    end
    mtmo[m] = 1'b0;
    if (mown[m] < 0 || rel) begin
      if (popped >= 0 && r[popped]) begin mown[m] = popped; mhold[m] = 1; end
      else mown[m] = -1;
    end else if (expd) begin
      mtmo[m] = 1'b1;
      if (had) begin
        mq[m].push_back(mown[m]);
        mpend[m][mown[m]] = 1'b1;
        if (r[popped]) begin mown[m] = popped; mhold[m] = 1; end
        else mown[m] = -1;
      end else begin
        mhold[m] = 1;
      end
    end else if (mmax[m] > 0 && mhold[m] < mmax[m]) begin
      mhold[m]++;
    end
    mprev[m] = r;
  endtask

  function automatic logic [N-1:0] exp_gnt(input int m);
    return (mown[m] >= 0) ? (N'(1) << mown[m]) : '0;
  endfunction

  function automatic logic [1:0] exp_id(input int m);
    return (mown[m] >= 0) ? 2'(mown[m]) : 2'd0;
  endfunction

  // Drive both request vectors, clock once, advance the model, land on negedge.
  task automatic tick(input logic [N-1:0] ra, input logic [N-1:0] rb);
    ifa.req = ra;
    ifb.req = rb;
    @(posedge clk);
    model_step(0, ra);
    model_step(1, rb);
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (ifa.gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt_a got=%b exp=0000", ifa.gnt); end
    n_checks++; if (ifa.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got=%b exp=0", ifa.gnt_valid); end
    n_checks++; if (ifa.gnt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id_a got=%0d exp=0", ifa.gnt_id); end
    n_checks++; if (ifa.queue_count !== 3'd0) begin n_fail++; $display("FAIL reset_count_a got=%0d exp=0", ifa.queue_count); end
    n_checks++; if (ifb.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_b got=%b exp=0", ifb.timeout); end
  endtask

  task automatic test_latency();
    tick(4'b0100, 4'b0);
    n_checks++; if (ifa.queue_count !== 3'd1) begin n_fail++; $display("FAIL lat_count_e1 got=%0d exp=1", ifa.queue_count); end
    n_checks++; if (ifa.gnt !== 4'b0) begin n_fail++; $display("FAIL lat_gnt_e1 got=%b exp=0000", ifa.gnt); end
    tick(4'b0100, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0100) begin n_fail++; $display("FAIL lat_gnt_e2 got=%b exp=0100", ifa.gnt); end
    n_checks++; if (ifa.gnt_id !== 2'd2) begin n_fail++; $display("FAIL lat_id_e2 got=%0d exp=2", ifa.gnt_id); end
    n_checks++; if (ifa.gnt_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid_e2 got=%b exp=1", ifa.gnt_valid); end
    n_checks++; if (ifa.queue_count !== 3'd0) begin n_fail++; $display("FAIL lat_count_e2 got=%0d exp=0", ifa.queue_count); end
    tick(4'b0, 4'b0);
    n_checks++; if (ifa.gnt_valid !== 1'b0 || ifa.gnt_id !== 2'd0) begin n_fail++; $display("FAIL lat_release got valid=%b id=%0d exp valid=0 id=0", ifa.gnt_valid, ifa.gnt_id); end
    tick(4'b0, 4'b0);
  endtask

  task automatic test_order();
    int rise [N] = '{2, 3, 99, 1};
    int held [N] = '{0, 0, 0, 0};
    bit done [N] = '{0, 0, 0, 0};
    int order[$];
    int cnt_seq[$];
    logic [N-1:0] r, prev_g;
    int gaps;
    prev_g = '0;
    gaps = 0;
    for (int c = 1; c <= 24; c++) begin
      r = '0;
      for (int i = 0; i < N; i++) if (c >= rise[i] && !done[i]) r[i] = 1'b1;
      tick(r, 4'b0);
      if (c <= 3) cnt_seq.push_back(int'(ifa.queue_count));
      if (ifa.gnt_valid && ifa.gnt !== prev_g) order.push_back(int'(ifa.gnt_id));
      if (order.size() > 0 && !(done[0] && done[1] && done[3]) && !ifa.gnt_valid) gaps++;
      for (int i = 0; i < N; i++) if (ifa.gnt[i]) begin held[i]++; if (held[i] == 4) done[i] = 1'b1; end
      prev_g = ifa.gnt;
    end
    n_checks++; if (order.size() != 3) begin n_fail++; $display("FAIL order_len got=%0d exp=3", order.size()); end
    n_checks++; if ((order.size() > 0 ? order[0] : -1) != 3) begin n_fail++; $display("FAIL order_first got=%0d exp=3", order.size() > 0 ? order[0] : -1); end
    n_checks++; if ((order.size() > 1 ? order[1] : -1) != 0) begin n_fail++; $display("FAIL order_second got=%0d exp=0", order.size() > 1 ? order[1] : -1); end
    n_checks++; if ((order.size() > 2 ? order[2] : -1) != 1) begin n_fail++; $display("FAIL order_third got=%0d exp=1", order.size() > 2 ? order[2] : -1); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL order_gap got=%0d idle cycles exp=0", gaps); end
    n_checks++; if (cnt_seq[0] != 1 || cnt_seq[1] != 1 || cnt_seq[2] != 2) begin n_fail++; $display("FAIL order_count got=%0d,%0d,%0d exp=1,1,2", cnt_seq[0], cnt_seq[1], cnt_seq[2]); end
  endtask

  task automatic test_simultaneous();
    tick(4'b0110, 4'b0);
    n_checks++; if (ifa.queue_count !== 3'd2) begin n_fail++; $display("FAIL simul_count got=%0d exp=2", ifa.queue_count); end
    tick(4'b0110, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0010) begin n_fail++; $display("FAIL simul_first got=%b exp=0010", ifa.gnt); end
    tick(4'b0110, 4'b0);
    tick(4'b0100, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0100) begin n_fail++; $display("FAIL simul_second got=%b exp=0100", ifa.gnt); end
    tick(4'b0, 4'b0);
    tick(4'b0, 4'b0);
  endtask

  task automatic test_timeout();
    tick(4'b0, 4'b0001);
    tick(4'b0, 4'b0001);
    tick(4'b0, 4'b0101);
    tick(4'b0, 4'b0101);
    n_checks++; if (ifb.timeout !== 1'b0 || ifb.gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_early got tmo=%b gnt=%b exp tmo=0 gnt=0001", ifb.timeout, ifb.gnt); end
    tick(4'b0, 4'b0101);
    n_checks++; if (ifb.timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got=%b exp=1", ifb.timeout); end
    n_checks++; if (ifb.gnt !== 4'b0100) begin n_fail++; $display("FAIL tmo_gnt got=%b exp=0100", ifb.gnt); end
    n_checks++; if (ifb.queue_count !== 3'd1) begin n_fail++; $display("FAIL tmo_count got=%0d exp=1", ifb.queue_count); end
    tick(4'b0, 4'b0101);
    n_checks++; if (ifb.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle got=%b exp=0", ifb.timeout); end
    tick(4'b0, 4'b0001);
    n_checks++; if (ifb.gnt !== 4'b0001 || ifb.queue_count !== 3'd0) begin n_fail++; $display("FAIL tmo_return got gnt=%b cnt=%0d exp gnt=0001 cnt=0", ifb.gnt, ifb.queue_count); end
    tick(4'b0, 4'b0001);
    tick(4'b0, 4'b0001);
    n_checks++; if (ifb.timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_regrant_early got=%b exp=0", ifb.timeout); end
    tick(4'b0, 4'b0001);
    n_checks++; if (ifb.timeout !== 1'b1 || ifb.gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_regrant got tmo=%b gnt=%b exp tmo=1 gnt=0001", ifb.timeout, ifb.gnt); end
    tick(4'b0, 4'b0);
    tick(4'b0, 4'b0);
  endtask

  task automatic test_withdraw();
    tick(4'b0001, 4'b0);
    tick(4'b0001, 4'b0);
    tick(4'b0011, 4'b0);
    tick(4'b0001, 4'b0);
    n_checks++; if (ifa.queue_count !== 3'd1) begin n_fail++; $display("FAIL wd_keep_entry got=%0d exp=1", ifa.queue_count); end
    tick(4'b1001, 4'b0);
    tick(4'b1000, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0 || ifa.queue_count !== 3'd1) begin n_fail++; $display("FAIL wd_discard got gnt=%b cnt=%0d exp gnt=0000 cnt=1", ifa.gnt, ifa.queue_count); end
    tick(4'b1000, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b1000 || ifa.queue_count !== 3'd0) begin n_fail++; $display("FAIL wd_grant got gnt=%b cnt=%0d exp gnt=1000 cnt=0", ifa.gnt, ifa.queue_count); end
    tick(4'b0, 4'b0);
    tick(4'b0, 4'b0);
  endtask

  task automatic test_reset_mid();
    tick(4'b0010, 4'b0);
    tick(4'b0010, 4'b0);
    tick(4'b1011, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0010 || ifa.queue_count !== 3'd2) begin n_fail++; $display("FAIL rmid_setup got gnt=%b cnt=%0d exp gnt=0010 cnt=2", ifa.gnt, ifa.queue_count); end
    #1 resetn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (ifa.gnt !== 4'b0 || ifa.queue_count !== 3'd0 || ifa.gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_clear got gnt=%b cnt=%0d valid=%b exp 0", ifa.gnt, ifa.queue_count, ifa.gnt_valid); end
    #2 resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(4'b1011, 4'b0);
      n_checks++; if (ifa.gnt !== 4'b0 || ifa.queue_count !== 3'd0) begin n_fail++; $display("FAIL rmid_held%0d got gnt=%b cnt=%0d exp gnt=0000 cnt=0", k, ifa.gnt, ifa.queue_count); end
    end
    tick(4'b0, 4'b0);
    tick(4'b1011, 4'b0);
    n_checks++; if (ifa.queue_count !== 3'd3) begin n_fail++; $display("FAIL rmid_redetect got=%0d exp=3", ifa.queue_count); end
    tick(4'b1011, 4'b0);
    n_checks++; if (ifa.gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_grant got=%b exp=0001", ifa.gnt); end
    repeat (4) tick(4'b0, 4'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    logic [N-1:0] g;
    logic v, t;
    logic [1:0] id;
    logic [2:0] qc;
    ra = '0;
    rb = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) ra[i] = ~ra[i];
        if ($urandom_range(0, 6) == 0) rb[i] = ~rb[i];
      end
      tick(ra, rb);
      for (int m = 0; m < 2; m++) begin
        g  = (m == 0) ? ifa.gnt : ifb.gnt;
        v  = (m == 0) ? ifa.gnt_valid : ifb.gnt_valid;
        id = (m == 0) ? ifa.gnt_id : ifb.gnt_id;
        qc = (m == 0) ? ifa.queue_count : ifb.queue_count;
        t  = (m == 0) ? ifa.timeout : ifb.timeout;
        n_checks++; if (g !== exp_gnt(m)) begin n_fail++; $display("FAIL rand_gnt dut=%0d cyc=%0d got=%b exp=%b", m, c, g, exp_gnt(m)); end
        n_checks++; if (v !== (mown[m] >= 0)) begin n_fail++; $display("FAIL rand_valid dut=%0d cyc=%0d got=%b exp=%b", m, c, v, mown[m] >= 0); end
        n_checks++; if (id !== exp_id(m)) begin n_fail++; $display("FAIL rand_id dut=%0d cyc=%0d got=%0d exp=%0d", m, c, id, exp_id(m)); end
        n_checks++; if (qc !== 3'(mq[m].size())) begin n_fail++; $display("FAIL rand_count dut=%0d cyc=%0d got=%0d exp=%0d", m, c, qc, mq[m].size()); end
        n_checks++; if (t !== mtmo[m]) begin n_fail++; $display("FAIL rand_timeout dut=%0d cyc=%0d got=%b exp=%b", m, c, t, mtmo[m]); end
      end
    end
    repeat (10) tick(4'b0, 4'b0);
  endtask

  initial begin
    resetn  = 1'b0;
    ifa.req = '0;
    ifb.req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    tick(4'b0, 4'b0);
    tick(4'b0, 4'b0);
    test_latency();
    test_order();
    test_simultaneous();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
